// File: rtl/z80_pio_host.sv
// z80_pio_host
// Drives a Z80 PIO with Z80-style I/O write, I/O read and interrupt
// acknowledge bus cycles. One command is in flight at a time.
//
// Ports
//   CLK        system clock, rising edge
//   RST_n      asynchronous reset, active HIGH (legacy name)
//   CMD_VALID/CMD_READY  command handshake (accepted when both high)
//   CMD_OP     00 write, 01 read, 10 interrupt acknowledge, 11 reserved (no-op)
//   CMD_ADDR   bit0 -> BASEL, bit1 -> CDSEL
//   CMD_DATA   write data
//   RSP_VALID/RSP_DATA   one-cycle response carrying read data or vector
//   CE, IORQ_n, RD_n, WR_n, M1_n   active-low strobes to the PIO
//   BASEL, CDSEL   PIO port/register select
//   ENA        one-cycle PIO clock-enable strobe
//   DO / DI    data to / from the PIO
//   INT_n      PIO interrupt request (asynchronous)
//   IRQ        synchronized active-high interrupt request
//
// State   | meaning
// --------+-----------------------------------------------
// IDLE    | ready for a command, bus strobes inactive
// T1      | address/select set up, CE low
// T2      | IORQ_n and RD_n/WR_n asserted
// TW      | wait cycles, strobes held
// T3      | strobes released, read response presented
// IA1     | intack: M1_n low
// IA2     | intack: M1_n low, wait counter loaded
// IA3     | intack: M1_n and IORQ_n low, vector captured at the end
// IA4     | intack: strobes released, vector presented

module z80_pio_host #(
  parameter int WAITS = 1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [1:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       CE,
  output logic       IORQ_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       M1_n,
  output logic       BASEL,
  output logic       CDSEL,
  output logic       ENA,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  input  logic       INT_n,
  output logic       IRQ
);

  localparam logic [3:0] LP_WAITS = 4'(WAITS);
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_IA  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_TW   = 4'd3,
    ST_T3   = 4'd4,
    ST_IA1  = 4'd5,
    ST_IA2  = 4'd6,
    ST_IA3  = 4'd7,
    ST_IA4  = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] r_op;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_rsp_data;
  logic       r_sync1;
  logic       r_sync2;
  logic       w_accept;
  logic       w_bus;
  logic       w_capture;

  // Ready is withheld while reset is held so nothing is accepted during reset.
  assign CMD_READY = (r_state == ST_IDLE) && !RST_n;
  assign w_accept  = CMD_VALID && CMD_READY;
  assign w_bus     = (r_state == ST_T1) || (r_state == ST_T2) ||
                     (r_state == ST_TW) || (r_state == ST_T3);
  // Writes also pulse ENA but must not disturb the last response.
  assign w_capture = ENA && ((r_state == ST_IA3) || (r_op == OP_RD));
  assign RSP_DATA  = r_rsp_data;
  assign IRQ       = r_sync2;

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 2'b00;
      r_addr  <= 2'b00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op   <= CMD_OP;
        r_addr <= CMD_ADDR;
        r_data <= CMD_DATA;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      r_rsp_data <= 8'h00;
    end else if (w_capture) begin
      r_rsp_data <= DI;
    end
  end

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~INT_n;
      r_sync2 <= r_sync1;
    end
  end

  // Wait counter: loaded on the way into TW/IA3 with the number of extra
  // cycles still to spend there; terminal count zero ends the phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (w_accept) begin
          case (CMD_OP)
            OP_WR, OP_RD: w_state_nxt = ST_T1;
            OP_IA:        w_state_nxt = ST_IA1;
            default:      w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_T1: w_state_nxt = ST_T2;
      ST_T2: begin
        if (LP_WAITS == 4'd0) begin
          w_state_nxt = ST_T3;
        end else begin
          w_state_nxt = ST_TW;
          w_cnt_nxt   = LP_WAITS - 4'd1;
        end
      end
      ST_TW: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_T3;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_T3:  w_state_nxt = ST_IDLE;
      ST_IA1: w_state_nxt = ST_IA2;
      ST_IA2: begin
        w_state_nxt = ST_IA3;
        w_cnt_nxt   = LP_WAITS;
      end
      ST_IA3: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IA4;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_IA4:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset releases
  // them in the same cycle.
  always_comb begin
    CE        = 1'b1;
    IORQ_n    = 1'b1;
    RD_n      = 1'b1;
    WR_n      = 1'b1;
    M1_n      = 1'b1;
    BASEL     = 1'b0;
    CDSEL     = 1'b0;
    DO        = 8'h00;
    ENA       = 1'b0;
    RSP_VALID = 1'b0;
    if (w_bus) begin
      CE    = 1'b0;
      BASEL = r_addr[0];
      CDSEL = r_addr[1];
      if (r_op == OP_WR) DO = r_data;
    end
    case (r_state)
      ST_T2, ST_TW: begin
        IORQ_n = 1'b0;
        WR_n   = (r_op != OP_WR);
        RD_n   = (r_op != OP_RD);
        if (r_state == ST_T2) ENA = (LP_WAITS == 4'd0);
        else                  ENA = (r_cnt == 4'd0);
      end
      ST_T3:  RSP_VALID = (r_op == OP_RD);
      ST_IA1, ST_IA2: M1_n = 1'b0;
      ST_IA3: begin
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        ENA    = (r_cnt == 4'd0);
      end
      ST_IA4:  RSP_VALID = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/z80_pio_host.md
Z80_PIO_HOST -- requirements
Module: z80_pio_host

Interface
REQ-001 Parameter WAITS, default 1, number of Tw wait cycles inserted while IORQ_n is low (legal 0..15).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_n  input  1  asynchronous, active-high reset.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high at a rising edge.
REQ-006 CMD_OP  input  2  00 I/O write, 01 I/O read, 10 interrupt acknowledge, 11 reserved.
REQ-007 CMD_ADDR  input  2  bit0 -> BASEL, bit1 -> CDSEL.
REQ-008 CMD_DATA  input  8  write data.
REQ-009 RSP_VALID  output  1  one-cycle pulse carrying read or vector data.
REQ-010 RSP_DATA  output  8  captured read data or interrupt vector.
REQ-011 CE, IORQ_n, RD_n, WR_n, M1_n  output  1 each  active-low Z80 bus strobes to the PIO.
REQ-012 BASEL, CDSEL  output  1 each  PIO port/register select.
REQ-013 ENA  output  1  one-cycle PIO clock-enable strobe.
REQ-014 DO  output  8  data to PIO DI.
REQ-015 DI  input  8  data from PIO DO.
REQ-016 INT_n  input  1  PIO interrupt request, asynchronous.
REQ-017 IRQ  output  1  synchronized, active-high copy of INT_n.

Function
REQ-018 FSM states: IDLE, T1, T2, TW, T3, IA1, IA2, IA3, IA4; 4-bit wait counter.
REQ-019 CMD_READY high only in IDLE; in all other states commands are not accepted and CMD_* are ignored.
REQ-020 Acceptance latches CMD_OP, CMD_ADDR, CMD_DATA; the bus cycle uses only the latched values.
REQ-021 Write/read path: IDLE -> T1 (1 cycle) -> T2 (1 cycle) -> TW (WAITS cycles, skipped if 0) -> T3 (1 cycle) -> IDLE.
REQ-022 T1..T3: CE=0; BASEL/CDSEL = latched address; DO = latched data for writes, 00h for reads.
REQ-023 T2 and TW: IORQ_n=0; WR_n=0 for write, RD_n=0 for read; all strobes high in T1 and T3.
REQ-024 ENA=1 only in the last IORQ_n-low cycle; a read captures DI into RSP_DATA at that edge.
REQ-025 For reads, RSP_VALID=1 for exactly the T3 cycle; for writes, RSP_VALID stays 0.
REQ-026 Interrupt acknowledge: IDLE -> IA1 -> IA2 -> IA3 (1+WAITS cycles) -> IA4 -> IDLE.
REQ-027 During IA1..IA3: M1_n=0, CE=1, RD_n=1, WR_n=1.
REQ-028 IORQ_n=0 only in IA3.
REQ-029 ENA=1 and DI captured into RSP_DATA in the last IA3 cycle.
REQ-030 IA4: all strobes high, RSP_VALID=1 for one cycle.
REQ-031 Reserved op 11 is accepted, produces no bus activity and no RSP_VALID, and CMD_READY returns high the next cycle.
REQ-032 M1_n is high in all non-IA states; IORQ_n and M1_n are never both low outside IA3.
REQ-033 RSP_DATA holds its last value until the next capture.
REQ-034 IRQ = NOT INT_n through a 2-flop synchronizer (2-cycle latency); independent of the FSM.
REQ-035 Throughput: a new command is accepted in the IDLE cycle following T3/IA4, so there is no back-to-back overlap.

Reset
REQ-036 RST_n high forces, immediately and without waiting for CLK: state IDLE, counter 0, CE/IORQ_n/RD_n/WR_n/M1_n=1, BASEL=CDSEL=0, DO=00h, ENA=0, RSP_VALID=0, RSP_DATA=00h, IRQ=0, synchronizer flops cleared.
REQ-037 CMD_READY=0 while reset is asserted; CMD_READY=1 at the first edge after release.
REQ-038 Reset asserted mid-cycle aborts the cycle with no ENA and no RSP_VALID, and no partial strobe persists.

Verification
REQ-039 WAITS=1, write OP=00 ADDR=00 DATA=A5h accepted at cycle k -> CE low k+1..k+4; WR_n/IORQ_n low k+2..k+3; ENA at k+3; DO=A5h; CMD_READY high at k+5.
REQ-040 WAITS=1, read OP=01 ADDR=01, DI=3Ch -> RD_n low k+2..k+3, BASEL=1, RSP_VALID at k+4 with RSP_DATA=3Ch, no WR_n activity.
REQ-041 WAITS=1, intack with DI=E0h -> M1_n low k+1..k+4, IORQ_n low k+3..k+4, CE high throughout, RSP_VALID at k+5 with E0h.
REQ-042 WAITS=0 then WAITS=15 builds: IORQ_n low-width equals 1 and 16 cycles respectively, with ENA in the final cycle.
REQ-043 Reset pulse during TW of a read -> all strobes high within the same cycle, no RSP_VALID; next command completes normally.
REQ-044 INT_n driven low -> IRQ=1 two edges later; CMD_VALID held high in non-IDLE states -> no second acceptance; reserved op -> no strobes.
